// File: rtl/vector_alu_pkg.sv
`default_nettype none
// ============================================================================
// vector_alu_pkg - opcode encodings and legality check for the vector ALU
// Rev 1.0
// ============================================================================
package vector_alu_pkg;

  localparam int ALUOP_W = 4;

  localparam logic [ALUOP_W-1:0] OP_MOVS = 4'd1;
  localparam logic [ALUOP_W-1:0] OP_ADD  = 4'd2;
  localparam logic [ALUOP_W-1:0] OP_SUB  = 4'd3;
  localparam logic [ALUOP_W-1:0] OP_XOR  = 4'd4;
  localparam logic [ALUOP_W-1:0] OP_AND  = 4'd5;
  localparam logic [ALUOP_W-1:0] OP_OR   = 4'd6;
  localparam logic [ALUOP_W-1:0] OP_SHL  = 4'd7;
  localparam logic [ALUOP_W-1:0] OP_SHR  = 4'd8;
  localparam logic [ALUOP_W-1:0] OP_ROL  = 4'd9;
  localparam logic [ALUOP_W-1:0] OP_ROR  = 4'd10;

  function automatic logic isLegalOp(input logic [ALUOP_W-1:0] op);
    return (op >= OP_MOVS) && (op <= OP_ROR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vector_alu_lane.sv
`default_nettype none
// ============================================================================
// vector_alu_lane - combinational single-lane ALU; ALU_SAT_EN adds ADD/SUB clamping
// Rev 1.0
// ============================================================================
module vector_alu_lane
  import vector_alu_pkg::*;
#(
  parameter int LANE_W = 8
) (
  input  logic [ALUOP_W-1:0] op,
  input  logic [LANE_W-1:0]  a,
  input  logic [LANE_W-1:0]  b,
  input  logic [LANE_W-1:0]  bcast,
  output logic [LANE_W-1:0]  res,
  output logic               carry,
  output logic               zero
);

  localparam int SHW = $clog2(LANE_W);
  localparam logic [LANE_W-1:0] c_lane_w = LANE_W'(LANE_W);

  logic [LANE_W:0]   w_sum;
  logic [LANE_W:0]   w_diff;
  logic [LANE_W-1:0] w_rot_amt;
  logic [LANE_W-1:0] w_rot_inv;
  logic              w_legal;

  // The extra top bit of the widened sum/difference is the carry/borrow.
  assign w_sum     = {1'b0, a} + {1'b0, b};
  assign w_diff    = {1'b0, a} - {1'b0, b};
  assign w_rot_amt = LANE_W'(b[SHW-1:0]);
  assign w_rot_inv = c_lane_w - w_rot_amt;

  always_comb begin
    res     = '0;
    carry   = 1'b0;
    w_legal = 1'b1;
    case (op)
      OP_MOVS: res = bcast;
      OP_ADD: begin
        carry = w_sum[LANE_W];
`ifdef ALU_SAT_EN
        res   = w_sum[LANE_W] ? '1 : w_sum[LANE_W-1:0];
`else
        res   = w_sum[LANE_W-1:0];
`endif
      end
      OP_SUB: begin
        carry = w_diff[LANE_W];
`ifdef ALU_SAT_EN
        res   = w_diff[LANE_W] ? '0 : w_diff[LANE_W-1:0];
`else
        res   = w_diff[LANE_W-1:0];
`endif
      end
      OP_XOR: res = a ^ b;
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_SHL: res = (b >= c_lane_w) ? '0 : (a << b);
      OP_SHR: res = (b >= c_lane_w) ? '0 : (a >> b);
      // A shift by the full lane width yields 0, so rotate-by-0 returns a unchanged.
      OP_ROL: res = (a << w_rot_amt) | (a >> w_rot_inv);
      OP_ROR: res = (a >> w_rot_amt) | (a << w_rot_inv);
      default: w_legal = 1'b0;
    endcase
  end

  assign zero = w_legal && (res == '0);

endmodule
`default_nettype wire

// File: rtl/vector_alu_pipe.sv
`default_nettype none
// ============================================================================
// vector_alu_pipe - 2-stage SIMD ALU with valid/ready handshake (ALU_SAT_EN: saturating ADD/SUB)
// Rev 1.0
// ============================================================================
module vector_alu_pipe
  import vector_alu_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int LANE_W = 8,
  parameter int ALUOP  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    inValid,
  output logic                    inReady,
  input  logic [ALUOP-1:0]        aluOP,
  input  logic [LANES*LANE_W-1:0] vectorA,
  input  logic [LANES*LANE_W-1:0] vectorB,
  output logic                    outValid,
  input  logic                    outReady,
  output logic [LANES*LANE_W-1:0] aluResult,
  output logic [LANES-1:0]        carryOut,
  output logic [LANES-1:0]        zeroOut,
  output logic                    opErr
);

  logic                    r_s1_valid;
  logic [ALUOP-1:0]        r_s1_op;
  logic [LANES*LANE_W-1:0] r_s1_a;
  logic [LANES*LANE_W-1:0] r_s1_b;

  logic                    r_s2_valid;
  logic [LANES*LANE_W-1:0] r_s2_res;
  logic [LANES-1:0]        r_s2_carry;
  logic [LANES-1:0]        r_s2_zero;
  logic                    r_s2_err;

  logic                    w_s2_adv;
  logic [LANES*LANE_W-1:0] w_res;
  logic [LANES-1:0]        w_carry;
  logic [LANES-1:0]        w_zero;
  logic                    w_err;

  // Ready looks through both stages so a draining consumer sustains one op per cycle.
  assign w_s2_adv = !r_s2_valid || outReady;
  assign inReady  = !r_s1_valid || w_s2_adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= '0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
    end else if (inReady) begin
      r_s1_valid <= inValid;
      if (inValid) begin
        r_s1_op <= aluOP;
        r_s1_a  <= vectorA;
        r_s1_b  <= vectorB;
      end
    end
  end

  generate
    for (genvar i = 0; i < LANES; i++) begin : g_lane
      vector_alu_lane #(
        .LANE_W (LANE_W)
      ) u_lane (
        .op    (r_s1_op),
        .a     (r_s1_a[i*LANE_W +: LANE_W]),
        .b     (r_s1_b[i*LANE_W +: LANE_W]),
        .bcast (r_s1_b[LANE_W-1:0]),
        .res   (w_res[i*LANE_W +: LANE_W]),
        .carry (w_carry[i]),
        .zero  (w_zero[i])
      );
    end
  endgenerate

  assign w_err = !isLegalOp(r_s1_op);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_res   <= '0;
      r_s2_carry <= '0;
      r_s2_zero  <= '0;
      r_s2_err   <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_res   <= w_res;
        r_s2_carry <= w_carry;
        r_s2_zero  <= w_zero;
        r_s2_err   <= w_err;
      end
    end
  end

  assign outValid  = r_s2_valid;
  assign aluResult = r_s2_res;
  assign carryOut  = r_s2_carry;
  assign zeroOut   = r_s2_zero;
  assign opErr     = r_s2_err;

endmodule
`default_nettype wire

// File: tb/tb_vector_alu_pipe.sv
`default_nettype none
// ============================================================================
// tb_vector_alu_pipe - directed and random checks of vector_alu_pipe (LANES=4, LANE_W=8)
// Rev 1.0
// ============================================================================
module tb_vector_alu_pipe;
  import vector_alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  alu_op = 4'd0;
  logic [31:0] vec_a = 32'd0;
  logic [31:0] vec_b = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] alu_res;
  logic [3:0]  carry_out;
  logic [3:0]  zero_out;
  logic        op_err;

  int total = 0;
  int bad   = 0;

  logic [31:0] q_res[$];
  logic [3:0]  q_c[$];
  logic [3:0]  q_z[$];
  logic        q_e[$];

  vector_alu_pipe #(
    .LANES  (4),
    .LANE_W (8),
    .ALUOP  (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .inValid   (in_valid),
    .inReady   (in_ready),
    .aluOP     (alu_op),
    .vectorA   (vec_a),
    .vectorB   (vec_b),
    .outValid  (out_valid),
    .outReady  (out_ready),
    .aluResult (alu_res),
    .carryOut  (carry_out),
    .zeroOut   (zero_out),
    .opErr     (op_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Reference behaviour, lane by lane with integer arithmetic.
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic [3:0] c,
                                output logic [3:0] z, output logic e);
    int av, bv, x, amt;
    e = !(op >= 4'd1 && op <= 4'd10);
    r = '0; c = '0; z = '0;
    for (int i = 0; i < 4; i++) begin
      av  = int'(a[i*8 +: 8]);
      bv  = int'(b[i*8 +: 8]);
      amt = bv % 8;
      case (op)
        4'd1:  x = int'(b[7:0]);
        4'd2: begin
          x = av + bv;
          c[i] = (x > 255);
`ifdef ALU_SAT_EN
          if (x > 255) x = 255;
`endif
        end
        4'd3: begin
          x = av - bv;
          c[i] = (av < bv);
`ifdef ALU_SAT_EN
          if (av < bv) x = 0;
`endif
        end
        4'd4:  x = av ^ bv;
        4'd5:  x = av & bv;
        4'd6:  x = av | bv;
        4'd7:  x = (bv >= 8) ? 0 : (av << bv);
        4'd8:  x = (bv >= 8) ? 0 : (av >> bv);
        4'd9:  x = (av << amt) | (av >> (8 - amt));
        4'd10: x = (av >> amt) | (av << (8 - amt));
        default: x = 0;
      endcase
      r[i*8 +: 8] = x[7:0];
      z[i] = !e && (x[7:0] == 8'd0);
    end
  endfunction

  // Scoreboard: records each transfer about to be taken and checks the head
  // of the queue whenever a result is presented.
  always begin
    logic [31:0] er;
    logic [3:0]  ec, ez;
    logic        ee;
    @(negedge clk);
    #2;
    if (!rst_n) begin
      q_res.delete(); q_c.delete(); q_z.delete(); q_e.delete();
    end else begin
      if (out_valid) begin
        if (q_res.size() == 0) begin
          chk("sb_spurious_out", 64'(out_valid), 64'd0);
        end else begin
          chk("sb_res",   64'(alu_res),   64'(q_res[0]));
          chk("sb_carry", 64'(carry_out), 64'(q_c[0]));
          chk("sb_zero",  64'(zero_out),  64'(q_z[0]));
          chk("sb_err",   64'(op_err),    64'(q_e[0]));
          if (out_ready) begin
            void'(q_res.pop_front()); void'(q_c.pop_front());
            void'(q_z.pop_front());   void'(q_e.pop_front());
          end
        end
      end
      if (in_valid && in_ready) begin
        model(alu_op, vec_a, vec_b, er, ec, ez, ee);
        q_res.push_back(er); q_c.push_back(ec); q_z.push_back(ez); q_e.push_back(ee);
      end
    end
  end

  task automatic send_check(input string nm, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] er, input logic [3:0] ec,
                            input logic [3:0] ez, input logic ee);
    int lat;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    alu_op    = op;
    vec_a     = a;
    vec_b     = b;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, "_lat"},   64'(lat),       64'd2);
    chk({nm, "_res"},   64'(alu_res),   64'(er));
    chk({nm, "_carry"}, 64'(carry_out), 64'(ec));
    chk({nm, "_zero"},  64'(zero_out),  64'(ez));
    chk({nm, "_err"},   64'(op_err),    64'(ee));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc, nxt, seen, first, last, nacc, cyc;
    logic take;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_res",       64'(alu_res),   64'd0);
    chk("rst_carry",     64'(carry_out), 64'd0);
    chk("rst_zero",      64'(zero_out),  64'd0);
    chk("rst_err",       64'(op_err),    64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    rst_n = 1'b1;

    // Directed vectors with hand-computed results
`ifdef ALU_SAT_EN
    send_check("add",  OP_ADD, 32'h010203F0, 32'h01010120, 32'h020304FF, 4'b0001, 4'b0000, 1'b0);
    send_check("sub",  OP_SUB, 32'h00000010, 32'h00000020, 32'h00000000, 4'b0001, 4'b1111, 1'b0);
`else
    send_check("add",  OP_ADD, 32'h010203F0, 32'h01010120, 32'h02030410, 4'b0001, 4'b0000, 1'b0);
    send_check("sub",  OP_SUB, 32'h00000010, 32'h00000020, 32'h000000F0, 4'b0001, 4'b1110, 1'b0);
`endif
    send_check("rol",  OP_ROL, 32'h00000081, 32'h00000003, 32'h0000000C, 4'b0000, 4'b1110, 1'b0);
    send_check("ror",  OP_ROR, 32'h00000081, 32'h00000009, 32'h000000C0, 4'b0000, 4'b1110, 1'b0);
    send_check("ror0", OP_ROR, 32'h000000A5, 32'h00000008, 32'h000000A5, 4'b0000, 4'b1110, 1'b0);
    send_check("shl",  OP_SHL, 32'h00000001, 32'h00000009, 32'h00000000, 4'b0000, 4'b1111, 1'b0);
    send_check("shr",  OP_SHR, 32'h80808080, 32'h08070100, 32'h00014080, 4'b0000, 4'b1000, 1'b0);
    send_check("movs", OP_MOVS, 32'hFFFFFFFF, 32'h1122335A, 32'h5A5A5A5A, 4'b0000, 4'b0000, 1'b0);
    send_check("ill",  4'd12,  32'hFFFFFFFF, 32'h01010101, 32'h00000000, 4'b0000, 4'b0000, 1'b1);

    // Backpressure: six numbered ops, consumer stalled
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    alu_op    = OP_ADD;
    vec_b     = 32'd0;
    nxt       = 1;
    vec_a     = 32'(nxt);
    acc       = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      take = in_valid && in_ready;
      if (take) acc++;
      @(negedge clk);
      if (take) begin
        nxt++;
        if (nxt > 6) in_valid = 1'b0;
        else vec_a = 32'(nxt);
      end
    end
    chk("bp_accepted",  64'(acc),      64'd2);
    chk("bp_ready_low", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    seen = 0; first = -1; last = -1;
    for (int c = 0; c < 30 && seen < 6; c++) begin
      #1;
      take = in_valid && in_ready;
      if (out_valid) begin
        seen++;
        chk("bp_order", 64'(alu_res), 64'(seen));
        if (seen == 1) first = c;
        last = c;
      end
      if (take) acc++;
      @(negedge clk);
      if (take) begin
        nxt++;
        if (nxt > 6) in_valid = 1'b0;
        else vec_a = 32'(nxt);
      end
    end
    chk("bp_count",       64'(seen),         64'd6);
    chk("bp_total_acc",   64'(acc),          64'd6);
    chk("bp_consecutive", 64'(last - first), 64'd5);

    // Asynchronous reset with both stages full
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    alu_op    = OP_XOR;
    vec_a     = 32'h11111111;
    vec_b     = 32'h01010101;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    chk("full_in_ready",  64'(in_ready),  64'd0);
    chk("full_out_valid", 64'(out_valid), 64'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_res",       64'(alu_res),   64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    send_check("post_rst", OP_OR, 32'h0F0000F0, 32'hF000000F, 32'hFF0000FF, 4'b0000, 4'b0110, 1'b0);

    // Random traffic against the scoreboard
    nacc = 0; cyc = 0; take = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    while (nacc < 10000 && cyc < 60000) begin
      if (!in_valid || take) begin
        in_valid = ($urandom_range(0, 4) != 0);
        alu_op   = 4'($urandom_range(0, 15));
        vec_a    = $urandom;
        vec_b    = $urandom;
        if ((alu_op == OP_SHL || alu_op == OP_SHR) && $urandom_range(0, 1) == 1)
          vec_b = vec_b & 32'h0F0F0F0F;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      take = in_valid && in_ready;
      if (take) nacc++;
      @(negedge clk);
      cyc++;
    end
    chk("rand_ops", 64'(nacc), 64'd10000);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    #3;
    chk("drain_empty", 64'(q_res.size()), 64'd0);
    chk("drain_valid", 64'(out_valid),    64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
